// File: rtl/output_sram_bank_arbiter.sv
// Banked output-activation SRAM controller.
// NUM_BANKS rows of (DATA_W/MACRO_W) 32x2048 macros, one write port and one read port
// per cycle (different banks), plus an accumulate (read-modify-write, lane-wise add) mode
// for partial-sum updates. Out-of-range banks are accepted, select nothing and are flagged.

// Behavioural stand-in for one sram_32_2048_freepdk45 column macro. Controls arrive
// from controller registers; read data is presented during the control cycle and a
// selected write lands at the end of that cycle.
module osba_macro_model #(
  parameter int DW = 32,
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          csb_i,
  input  logic          web_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Commit a selected write at the end of the control cycle.
  always_ff @(posedge clk_i) begin
    if (!csb_i && !web_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

module output_sram_bank_arbiter #(
  parameter int DATA_W     = 128,
  parameter int MACRO_W    = 32,
  parameter int ROW_ADDR_W = 11,
  parameter int NUM_BANKS  = 6,
  parameter int ADDR_W     = 14,
  parameter int LANE_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              w_en_i,
  input  logic              w_acc_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_d_i,
  output logic              w_ready_o,
  output logic              w_done_o,
  input  logic              r_en_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              r_ready_o,
  output logic [DATA_W-1:0] r_d_o,
  output logic              d_ready_o,
  output logic              addr_err_o
);

  localparam int COLS   = DATA_W / MACRO_W;
  localparam int LANES  = DATA_W / LANE_W;
  localparam int BANK_W = ADDR_W - ROW_ADDR_W;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RD   = 2'd1,
    W_ADD  = 2'd2,
    W_WR   = 2'd3
  } wstate_e;

  // A bank index is serviceable only when a macro row exists for it.
  function automatic logic bank_valid(input logic [BANK_W-1:0] bank);
    return (int'(bank) < NUM_BANKS);
  endfunction

  // Lane-wise two's-complement add; carries never cross a lane boundary.
  function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int l = 0; l < LANES; l++) begin
      s[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
    end
    return s;
  endfunction

  // Request decode
  logic [BANK_W-1:0]     w_bank_s, r_bank_s;
  logic [ROW_ADDR_W-1:0] w_row_s, r_row_s;
  logic                  w_ok_s, r_ok_s;
  logic                  acc_busy_s, w_ready_s, r_ready_s, w_fire_s, r_fire_s;

  // Control state
  logic    alive_q;
  wstate_e state_q, state_d;

  // Accumulate context
  logic [BANK_W-1:0]     acc_bank_q;
  logic [ROW_ADDR_W-1:0] acc_row_q;
  logic [DATA_W-1:0]     acc_d_q;
  logic                  acc_err_q;
  logic [DATA_W-1:0]     old_q;
  logic [DATA_W-1:0]     acc_sum_s;

  // Pipeline and output registers
  logic              wr_pend_q, wr_err_q;
  logic              rd_pend_q, rd_err_q;
  logic [BANK_W-1:0] rd_bank_q;
  logic              w_done_q, d_ready_q, addr_err_q;
  logic [DATA_W-1:0] r_d_q;

  // Per-bank macro controls (shared across the columns of a bank)
  logic [NUM_BANKS-1:0]  csb_q, csb_d, web_q, web_d;
  logic [ROW_ADDR_W-1:0] mac_addr_q [NUM_BANKS];
  logic [ROW_ADDR_W-1:0] mac_addr_d [NUM_BANKS];
  logic [DATA_W-1:0]     mac_din_q  [NUM_BANKS];
  logic [DATA_W-1:0]     mac_din_d  [NUM_BANKS];
  logic [MACRO_W-1:0]    mac_dout_s [NUM_BANKS][COLS];
  logic [DATA_W-1:0]     rd_dout_s, acc_dout_s;

  assign w_bank_s = w_addr_i[ADDR_W-1:ROW_ADDR_W];
  assign r_bank_s = r_addr_i[ADDR_W-1:ROW_ADDR_W];
  assign w_row_s  = w_addr_i[ROW_ADDR_W-1:0];
  assign r_row_s  = r_addr_i[ROW_ADDR_W-1:0];
  assign w_ok_s   = bank_valid(w_bank_s);
  assign r_ok_s   = bank_valid(r_bank_s);

  // Writes always win: a read yields to a same-bank write accepted this cycle and to
  // the bank held by an accumulate between its read and its write-back.
  assign acc_busy_s = (state_q != W_IDLE);
  assign w_ready_s  = alive_q && !acc_busy_s;
  assign w_fire_s   = w_en_i && w_ready_s;
  assign r_ready_s  = alive_q
                      && !(w_fire_s && (r_bank_s == w_bank_s))
                      && !(acc_busy_s && (r_bank_s == acc_bank_q));
  assign r_fire_s   = r_en_i && r_ready_s;

  assign acc_sum_s  = lane_add(old_q, acc_d_q);

  assign w_ready_o  = w_ready_s;
  assign r_ready_o  = r_ready_s;
  assign w_done_o   = w_done_q;
  assign d_ready_o  = d_ready_q;
  assign addr_err_o = addr_err_q;
  assign r_d_o      = r_d_q;

  // Accumulate sequencer next state: read, add, write back, then idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE: begin
        if (w_fire_s && w_acc_i) begin
          state_d = W_RD;
        end else begin
          state_d = W_IDLE;
        end
      end
      W_RD:    state_d = W_ADD;
      W_ADD:   state_d = W_WR;
      W_WR:    state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Next macro controls: every bank idles unless this cycle's traffic addresses it.
  always_comb begin
    csb_d      = '1;
    web_d      = '1;
    mac_addr_d = mac_addr_q;
    mac_din_d  = mac_din_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if ((state_q == W_ADD) && (acc_bank_q == BANK_W'(b))) begin
        csb_d[b]      = 1'b0;
        web_d[b]      = 1'b0;
        mac_addr_d[b] = acc_row_q;
        mac_din_d[b]  = acc_sum_s;
      end else if (w_fire_s && (w_bank_s == BANK_W'(b))) begin
        csb_d[b]      = 1'b0;
        web_d[b]      = w_acc_i;
        mac_addr_d[b] = w_row_s;
        mac_din_d[b]  = w_d_i;
      end else if (r_fire_s && (r_bank_s == BANK_W'(b))) begin
        csb_d[b]      = 1'b0;
        web_d[b]      = 1'b1;
        mac_addr_d[b] = r_row_s;
      end else begin
        csb_d[b]      = 1'b1;
        web_d[b]      = 1'b1;
      end
    end
  end

  // AND-OR select of the bank feeding the pending read and the accumulate read.
  always_comb begin
    rd_dout_s  = '0;
    acc_dout_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int c = 0; c < COLS; c++) begin
        rd_dout_s[c*MACRO_W +: MACRO_W]  = rd_dout_s[c*MACRO_W +: MACRO_W]
            | (mac_dout_s[b][c] & {MACRO_W{rd_bank_q == BANK_W'(b)}});
        acc_dout_s[c*MACRO_W +: MACRO_W] = acc_dout_s[c*MACRO_W +: MACRO_W]
            | (mac_dout_s[b][c] & {MACRO_W{acc_bank_q == BANK_W'(b)}});
      end
    end
  end

  // Liveness, sequencer state and macro control registers; reset deselects every bank.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alive_q <= 1'b0;
      state_q <= W_IDLE;
      csb_q   <= '1;
      web_q   <= '1;
      for (int b = 0; b < NUM_BANKS; b++) begin
        mac_addr_q[b] <= '0;
        mac_din_q[b]  <= '0;
      end
    end else begin
      alive_q    <= 1'b1;
      state_q    <= state_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      mac_addr_q <= mac_addr_d;
      mac_din_q  <= mac_din_d;
    end
  end

  // Capture the accumulate request and the old row contents read during W_RD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_bank_q <= '0;
      acc_row_q  <= '0;
      acc_d_q    <= '0;
      acc_err_q  <= 1'b0;
      old_q      <= '0;
    end else begin
      if (w_fire_s && w_acc_i) begin
        acc_bank_q <= w_bank_s;
        acc_row_q  <= w_row_s;
        acc_d_q    <= w_d_i;
        acc_err_q  <= !w_ok_s;
      end
      if (state_q == W_RD) begin
        old_q <= acc_dout_s;
      end
    end
  end

  // Completion pipeline: done/ready pulses two cycles after accept (four for accumulate).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_pend_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_bank_q  <= '0;
      w_done_q   <= 1'b0;
      d_ready_q  <= 1'b0;
      addr_err_q <= 1'b0;
      r_d_q      <= '0;
    end else begin
      wr_pend_q  <= w_fire_s && !w_acc_i;
      wr_err_q   <= !w_ok_s;
      rd_pend_q  <= r_fire_s;
      rd_err_q   <= !r_ok_s;
      rd_bank_q  <= r_bank_s;
      w_done_q   <= wr_pend_q || (state_q == W_WR);
      d_ready_q  <= rd_pend_q;
      addr_err_q <= (wr_pend_q && wr_err_q)
                    || ((state_q == W_WR) && acc_err_q)
                    || (rd_pend_q && rd_err_q);
      if (rd_pend_q) begin
        r_d_q <= rd_err_q ? '0 : rd_dout_s;
      end
    end
  end

  // Macro array: NUM_BANKS rows by COLS columns.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar c = 0; c < COLS; c++) begin : g_col
      osba_macro_model #(
        .DW (MACRO_W),
        .AW (ROW_ADDR_W)
      ) u_macro (
        .clk_i  (clk_i),
        .csb_i  (csb_q[b]),
        .web_i  (web_q[b]),
        .addr_i (mac_addr_q[b]),
        .din_i  (mac_din_q[b][c*MACRO_W +: MACRO_W]),
        .dout_o (mac_dout_s[b][c])
      );
    end
  end

endmodule

// File: tb/tb_output_sram_bank_arbiter.sv
// Randomized bench for output_sram_bank_arbiter with a transaction-level reference:
// memory is a map from address to word, each accepted op is applied in acceptance
// order, and its completion pulses are scheduled at accept+2 (accept+4 for accumulate).
module tb_output_sram_bank_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         w_en, w_acc, r_en;
  logic [13:0]  w_addr, r_addr;
  logic [127:0] w_d;
  logic         w_ready, w_done, r_ready, d_ready, addr_err;
  logic [127:0] r_d;

  output_sram_bank_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .w_en_i     (w_en),
    .w_acc_i    (w_acc),
    .w_addr_i   (w_addr),
    .w_d_i      (w_d),
    .w_ready_o  (w_ready),
    .w_done_o   (w_done),
    .r_en_i     (r_en),
    .r_addr_i   (r_addr),
    .r_ready_o  (r_ready),
    .r_d_o      (r_d),
    .d_ready_o  (d_ready),
    .addr_err_o (addr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference state
  bit           alive;
  int           acc_cyc;
  logic [2:0]   acc_bank;
  logic [127:0] mem [logic [13:0]];
  bit           sch_wd [int];
  bit           sch_dr [int];
  bit           sch_er [int];
  logic [127:0] sch_rd [int];
  logic [127:0] rd_hold;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [2:0] bank_of(input logic [13:0] a);
    return a[13:11];
  endfunction

  function automatic logic [127:0] lanes_sum(input logic [127:0] o, input logic [127:0] d);
    logic [127:0] n;
    for (int l = 0; l < 4; l++) n[l*32 +: 32] = o[l*32 +: 32] + d[l*32 +: 32];
    return n;
  endfunction

  function automatic logic [127:0] mem_rd(input logic [13:0] a);
    if (bank_of(a) >= 3'd6) return 128'd0;
    if (mem.exists(a)) return mem[a];
    return 128'd0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    alive   = 1'b0;
    acc_cyc = -100;
    acc_bank = 3'd0;
    rd_hold = 128'd0;
    mem.delete();
    sch_wd.delete();
    sch_dr.delete();
    sch_er.delete();
    sch_rd.delete();
  endtask

  // One clock cycle: drive, check against the reference at the falling edge, account accepts.
  task automatic step(input bit we, input bit wa, input logic [13:0] waddr, input logic [127:0] wd,
                      input bit re, input logic [13:0] raddr);
    bit acc_busy, exp_wr, exp_rr, wf, rf;
    int dc;
    w_en = we; w_acc = wa; w_addr = waddr; w_d = wd; r_en = re; r_addr = raddr;
    @(negedge clk);
    acc_busy = (cyc > acc_cyc) && (cyc < acc_cyc + 4);
    exp_wr   = alive && !acc_busy;
    wf       = we && exp_wr;
    exp_rr   = alive && !(wf && (bank_of(raddr) == bank_of(waddr)))
                     && !(acc_busy && (bank_of(raddr) == acc_bank));
    rf       = re && exp_rr;
    if (sch_dr.exists(cyc)) rd_hold = sch_rd[cyc];
    check("w_ready",  w_ready,  exp_wr);
    check("r_ready",  r_ready,  exp_rr);
    check("w_done",   w_done,   sch_wd.exists(cyc));
    check("d_ready",  d_ready,  sch_dr.exists(cyc));
    check("addr_err", addr_err, sch_er.exists(cyc));
    check("r_d",      r_d,      rd_hold);
    if (rf) begin
      sch_dr[cyc+2] = 1'b1;
      sch_rd[cyc+2] = mem_rd(raddr);
      if (bank_of(raddr) >= 3'd6) sch_er[cyc+2] = 1'b1;
    end
    if (wf) begin
      dc = wa ? cyc + 4 : cyc + 2;
      sch_wd[dc] = 1'b1;
      if (bank_of(waddr) >= 3'd6) sch_er[dc] = 1'b1;
      else mem[waddr] = wa ? lanes_sum(mem_rd(waddr), wd) : wd;
      if (wa) begin
        acc_cyc  = cyc;
        acc_bank = bank_of(waddr);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 14'd0, 128'd0, 1'b0, 14'd0);
  endtask

  task automatic prefill();
    for (int b = 0; b < 6; b++)
      for (int r = 0; r < 4; r++)
        step(1'b1, 1'b0, {3'(b), 11'(r)}, rnd128(), 1'b0, 14'd0);
    idle(2);
  endtask

  function automatic logic [13:0] rnd_addr();
    logic [2:0] b;
    b = 3'($urandom_range(0, 6));
    return {b, 11'($urandom_range(0, 3))};
  endfunction

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, rnd_addr(), rnd128(),
           $urandom_range(0, 9) < 6, rnd_addr());
    idle(5);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_w_ready"},  w_ready,  1'b0);
    check({tag, "_r_ready"},  r_ready,  1'b0);
    check({tag, "_w_done"},   w_done,   1'b0);
    check({tag, "_d_ready"},  d_ready,  1'b0);
    check({tag, "_addr_err"}, addr_err, 1'b0);
    check({tag, "_r_d"},      r_d,      128'd0);
  endtask

  localparam logic [127:0] T1D = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] T2P = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] T2A = {32'hFFFFFFFF, 32'd30, 32'd20, 32'd10};
  localparam logic [127:0] T2E = {32'd3, 32'd33, 32'd22, 32'd11};

  initial begin
    logic [127:0] d4;
    rst_n = 1'b0;
    w_en = 1'b0; w_acc = 1'b0; w_addr = 14'd0; w_d = 128'd0; r_en = 1'b0; r_addr = 14'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    alive = 1'b1;

    prefill();

    // T1: plain write then read of bank 1 row 5
    step(1'b1, 1'b0, 14'h0805, T1D, 1'b0, 14'd0);
    step(1'b0, 1'b0, 14'd0, 128'd0, 1'b1, 14'h0805);
    idle(2);
    check("t1_rdata", r_d, T1D);

    // T2: accumulate with per-lane wrap
    step(1'b1, 1'b0, 14'h0002, T2P, 1'b0, 14'd0);
    step(1'b1, 1'b1, 14'h0002, T2A, 1'b0, 14'd0);
    idle(3);
    step(1'b0, 1'b0, 14'd0, 128'd0, 1'b1, 14'h0002);
    idle(2);
    check("t2_rdata", r_d, T2E);

    // T3: write bank 0 and read bank 2 in the same cycle
    step(1'b1, 1'b0, 14'h0001, rnd128(), 1'b1, 14'h1001);
    idle(3);

    // T4: same-bank write and read; read retried next cycle sees new data
    d4 = rnd128();
    step(1'b1, 1'b0, 14'h1000, d4, 1'b1, 14'h1000);
    step(1'b0, 1'b0, 14'd0, 128'd0, 1'b1, 14'h1000);
    idle(2);
    check("t4_rdata", r_d, d4);

    // T5: out-of-range write, then read back every valid row and the bad address
    step(1'b1, 1'b0, 14'h3000, rnd128(), 1'b0, 14'd0);
    idle(2);
    for (int b = 0; b < 6; b++)
      for (int r = 0; r < 4; r++)
        step(1'b0, 1'b0, 14'd0, 128'd0, 1'b1, {3'(b), 11'(r)});
    step(1'b0, 1'b0, 14'd0, 128'd0, 1'b1, 14'h3000);
    idle(2);
    check("t5_rdata_oor", r_d, 128'd0);

    random_run(400);

    // T6: reset during W_ADD drops the accumulate with no done pulse
    step(1'b1, 1'b1, 14'h0803, rnd128(), 1'b0, 14'd0);
    step(1'b0, 1'b0, 14'd0, 128'd0, 1'b0, 14'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_assert");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_outputs_zero("t6_held");
    end
    rst_n = 1'b1;
    #1;
    check("t6_w_ready_pre", w_ready, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    alive = 1'b1;
    check("t6_w_ready_post", w_ready, 1'b1);
    check("t6_r_ready_post", r_ready, 1'b1);

    prefill();
    random_run(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
